// File: rtl/dma_axi_mm_responder.sv
`default_nettype none
// ============================================================================
// Module   : dma_axi_mm_responder
// Purpose  : AXI4-MM responder backed by an on-chip RAM. Answers the AR/R and
//            AW/W/B traffic routed to a memory port; used as a local stand-in
//            for host/DDR memory in loopback and bring-up builds.
// Ports    : clk, reset_n (async, active low)
//            AW : awvalid/awready, awid, awaddr, awlen
//            W  : wvalid/wready, wdata, wstrb, wlast
//            B  : bvalid/bready, bid, bresp
//            AR : arvalid/arready, arid, araddr, arlen
//            R  : rvalid/rready, rid, rdata, rresp, rlast
// Options  : DMA_AXI_RESP_RANGE_ERR_EN - beats whose index runs past the top
//            of the RAM get SLVERR (writes dropped, reads return zero).
//            Undefined: indices wrap silently and every response is OKAY.
// Revision : 1.0 - initial release
// ============================================================================
module dma_axi_mm_responder #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int ID_WIDTH   = 9,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast
);

    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int OFFW   = $clog2(BYTES);
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [1:0] C_OKAY   = 2'b00;
    localparam logic [1:0] C_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_BURST = 2'd2} rstate_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Ready outputs stay low until the first clock after reset release.
    logic                  rdy_q;

    wstate_t               wstate_q, wstate_d;
    logic [ID_WIDTH-1:0]   wid_q, wid_d;
    logic [DEPTH_LOG2-1:0] widx_q, widx_d;
    logic [7:0]            wlen_q, wlen_d;
    logic [7:0]            wcnt_q, wcnt_d;

    rstate_t               rstate_q, rstate_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [DEPTH_LOG2-1:0] ridx_q, ridx_d;
    logic [7:0]            rlen_q, rlen_d;
    logic [7:0]            rcnt_q, rcnt_d;
    logic [DATA_WIDTH-1:0] ram_dout_q;

    logic                  w_aw_hs, w_w_hs, w_ar_hs, w_r_last, w_r_adv;
    logic                  w_ram_re;
    logic [DEPTH_LOG2-1:0] w_raddr;
    logic                  w_wbeat_err;
    logic                  w_unused;

    assign w_aw_hs  = awvalid && awready;
    assign w_w_hs   = wvalid && wready;
    assign w_ar_hs  = arvalid && arready;
    assign w_r_last = (rstate_q == R_BURST) && (rcnt_q == rlen_q);
    // Advance to the next beat only on an accepted, non-final beat.
    assign w_r_adv  = (rstate_q == R_BURST) && rready && !w_r_last;
    // Fetch the first beat in R_FETCH; afterwards prefetch the following word
    // on each accepted beat so the data register always holds the live beat.
    assign w_ram_re = (rstate_q == R_FETCH) || w_r_adv;
    assign w_raddr  = (rstate_q == R_FETCH) ? ridx_q : ridx_q + 1'b1;

    // wlast is not used: the burst ends on the beat counter alone.
    assign w_unused = &{1'b0, wlast, awaddr, araddr};

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_q    <= 1'b0;
            wstate_q <= W_IDLE;
            wid_q    <= '0;
            widx_q   <= '0;
            wlen_q   <= '0;
            wcnt_q   <= '0;
            rstate_q <= R_IDLE;
            rid_q    <= '0;
            ridx_q   <= '0;
            rlen_q   <= '0;
            rcnt_q   <= '0;
        end else begin
            rdy_q    <= 1'b1;
            wstate_q <= wstate_d;
            wid_q    <= wid_d;
            widx_q   <= widx_d;
            wlen_q   <= wlen_d;
            wcnt_q   <= wcnt_d;
            rstate_q <= rstate_d;
            rid_q    <= rid_d;
            ridx_q   <= ridx_d;
            rlen_q   <= rlen_d;
            rcnt_q   <= rcnt_d;
        end
    end

    // ---------------------------------------------------------- write FSM
    always_comb begin
        wstate_d = wstate_q;
        wid_d    = wid_q;
        widx_d   = widx_q;
        wlen_d   = wlen_q;
        wcnt_d   = wcnt_q;
        awready  = 1'b0;
        wready   = 1'b0;
        bvalid   = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                awready = rdy_q;
                if (awvalid && rdy_q) begin
                    wid_d    = awid;
                    widx_d   = awaddr[DEPTH_LOG2+OFFW-1:OFFW];
                    wlen_d   = awlen;
                    wcnt_d   = 8'd0;
                    wstate_d = W_DATA;
                end
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    widx_d = widx_q + 1'b1;
                    wcnt_d = wcnt_q + 8'd1;
                    if (wcnt_q == wlen_q) begin
                        wstate_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    assign bid = wid_q;

    // ----------------------------------------------------------- read FSM
    always_comb begin
        rstate_d = rstate_q;
        rid_d    = rid_q;
        ridx_d   = ridx_q;
        rlen_d   = rlen_q;
        rcnt_d   = rcnt_q;
        arready  = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                arready = rdy_q;
                if (arvalid && rdy_q) begin
                    rid_d    = arid;
                    ridx_d   = araddr[DEPTH_LOG2+OFFW-1:OFFW];
                    rlen_d   = arlen;
                    rcnt_d   = 8'd0;
                    rstate_d = R_FETCH;
                end
            end
            R_FETCH: rstate_d = R_BURST;
            R_BURST: begin
                if (rready) begin
                    if (rcnt_q == rlen_q) begin
                        rstate_d = R_IDLE;
                    end else begin
                        rcnt_d = rcnt_q + 8'd1;
                        ridx_d = ridx_q + 1'b1;
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    assign rvalid = (rstate_q == R_BURST);
    assign rlast  = w_r_last;
    assign rid    = rid_q;

    // ------------------------------------------------------------- memory
    // Non-blocking write and read on the same edge: a colliding read sees
    // the old word.
    always_ff @(posedge clk) begin
        if (w_w_hs && !w_wbeat_err) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wstrb[b]) begin
                    mem[widx_q][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
        if (w_ram_re) begin
            ram_dout_q <= mem[w_raddr];
        end
    end

`ifdef DMA_AXI_RESP_RANGE_ERR_EN
    // The *over flags record that the running index has wrapped past the top
    // of the RAM, i.e. the current beat's unwrapped index is out of range.
    logic wover_q, werr_q, rover_q, rerr_q;
    logic w_rfetch_err;

    assign w_wbeat_err  = wover_q;
    // The first beat can never be out of range; later beats inherit any wrap.
    assign w_rfetch_err = (rstate_q == R_FETCH) ? 1'b0 : (rover_q || (&ridx_q));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wover_q <= 1'b0;
            werr_q  <= 1'b0;
            rover_q <= 1'b0;
            rerr_q  <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                wover_q <= 1'b0;
                werr_q  <= 1'b0;
            end else if (w_w_hs) begin
                if (&widx_q) wover_q <= 1'b1;
                if (wover_q) werr_q  <= 1'b1;
            end
            if (w_ar_hs) begin
                rover_q <= 1'b0;
            end else if (w_r_adv && (&ridx_q)) begin
                rover_q <= 1'b1;
            end
            if (w_ram_re) begin
                rerr_q <= w_rfetch_err;
            end
        end
    end

    assign bresp = (bvalid && werr_q) ? C_SLVERR : C_OKAY;
    assign rresp = (rvalid && rerr_q) ? C_SLVERR : C_OKAY;
    assign rdata = rerr_q ? '0 : ram_dout_q;
`else
    assign w_wbeat_err = 1'b0;
    assign bresp       = C_OKAY;
    assign rresp       = C_OKAY;
    assign rdata       = ram_dout_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dma_axi_mm_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_axi_mm_responder
// Purpose  : Directed self-checking bench for dma_axi_mm_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_axi_mm_responder;
    localparam int AW = 64, DW = 512, IW = 9, DL = 10, BY = DW / 8;

    logic          clk = 1'b0, reset_n = 1'b0;
    logic          awvalid = 0, wvalid = 0, wlast = 0, bready = 0, arvalid = 0, rready = 0;
    logic [IW-1:0] awid = '0, arid = '0;
    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic [7:0]    awlen = '0, arlen = '0;
    logic [DW-1:0] wdata = '0;
    logic [BY-1:0] wstrb = '0;
    logic          awready, wready, bvalid, arready, rvalid, rlast;
    logic [IW-1:0] bid, rid;
    logic [1:0]    bresp, rresp;
    logic [DW-1:0] rdata;

    int n_cmp = 0, n_err = 0, cyc = 0;
    logic [DW-1:0] rd_data [256];
    logic          rd_last [256];
    logic [IW-1:0] rd_id   [256];
    logic [1:0]    rd_resp [256];
    int            rd_cyc  [256];
    int            rd_lat;
    logic [IW-1:0] b_id;
    logic [1:0]    b_resp;

    dma_axi_mm_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEPTH_LOG2(DL)) dut (
        .clk(clk), .reset_n(reset_n),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] pat(input int k);
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = 32'(k * 65536 + i * 4099 + 1);
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input int id, input int word, input int len);
        int n = 0;
        awid = IW'(id); awaddr = AW'(word * BY); awlen = 8'(len); awvalid = 1'b1;
        while (!awready && n < 100) begin tick; n++; end
        if (n >= 100) begin n_cmp++; n_err++; $display("FAIL aw_timeout got awready=%b want 1", awready); end
        tick;
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [DW-1:0] d, input logic [BY-1:0] s, input logic l);
        int n = 0;
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        while (!wready && n < 100) begin tick; n++; end
        if (n >= 100) begin n_cmp++; n_err++; $display("FAIL w_timeout got wready=%b want 1", wready); end
        tick;
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic get_b;
        int n = 0;
        bready = 1'b1;
        while (!bvalid && n < 100) begin tick; n++; end
        if (n >= 100) begin n_cmp++; n_err++; $display("FAIL b_timeout got bvalid=%b want 1", bvalid); end
        b_id = bid; b_resp = bresp;
        tick;
        bready = 1'b0;
    endtask

    task automatic write_burst(input int id, input int word, input int len, input int k0);
        send_aw(id, word, len);
        for (int k = 0; k <= len; k++) send_w(pat(k0 + k), '1, k == len);
        get_b();
    endtask

    task automatic read_burst(input int id, input int word, input int len);
        int n = 0, k = 0, t_hs;
        arid = IW'(id); araddr = AW'(word * BY); arlen = 8'(len); arvalid = 1'b1;
        while (!arready && n < 100) begin tick; n++; end
        if (n >= 100) begin n_cmp++; n_err++; $display("FAIL ar_timeout got arready=%b want 1", arready); end
        t_hs = cyc;
        tick;
        arvalid = 1'b0; rready = 1'b1; n = 0;
        while (k <= len && n < 1000) begin
            if (rvalid) begin
                rd_data[k] = rdata; rd_last[k] = rlast; rd_id[k] = rid;
                rd_resp[k] = rresp; rd_cyc[k] = cyc; k++;
            end
            tick; n++;
        end
        rready = 1'b0;
        if (n >= 1000) begin n_cmp++; n_err++; $display("FAIL r_timeout got beats=%0d want %0d", k, len + 1); end
        rd_lat = rd_cyc[0] - t_hs;
    endtask

    task automatic test_reset;
        repeat (3) tick;
        n_cmp++; if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b0) begin
            n_err++; $display("FAIL reset_ctrl got %b want 000000", {awready, arready, wready, bvalid, rvalid, rlast}); end
        n_cmp++; if ({bresp, rresp, bid, rid} !== '0) begin
            n_err++; $display("FAIL reset_resp_id got %h want 0", {bresp, rresp, bid, rid}); end
        @(negedge clk) reset_n = 1'b1;
        tick;
        n_cmp++; if ({awready, arready} !== 2'b11) begin
            n_err++; $display("FAIL idle_ready got %b want 11", {awready, arready}); end
    endtask

    task automatic test_burst;
        write_burst(5, 1, 3, 1);
        n_cmp++; if ({b_id, b_resp} !== {9'd5, 2'b00}) begin
            n_err++; $display("FAIL burst_b got id=%0d resp=%b want id=5 resp=00", b_id, b_resp); end
        n_cmp++; if (bvalid !== 1'b0) begin
            n_err++; $display("FAIL burst_b_single got bvalid=%b want 0", bvalid); end
        read_burst(7, 1, 3);
        n_cmp++; if (rd_lat !== 2) begin
            n_err++; $display("FAIL burst_latency got %0d want 2", rd_lat); end
        n_cmp++; if (rd_cyc[3] - rd_cyc[0] !== 3) begin
            n_err++; $display("FAIL burst_b2b got span %0d want 3", rd_cyc[3] - rd_cyc[0]); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (rd_data[k] !== pat(1 + k)) begin
                n_err++; $display("FAIL burst_data[%0d] got %h want %h", k, rd_data[k], pat(1 + k)); end
            n_cmp++; if ({rd_id[k], rd_last[k], rd_resp[k]} !== {9'd7, k == 3, 2'b00}) begin
                n_err++; $display("FAIL burst_ctl[%0d] got id=%0d last=%b resp=%b want id=7 last=%b resp=00",
                                  k, rd_id[k], rd_last[k], rd_resp[k], k == 3); end
        end
    endtask

    task automatic test_strobe;
        logic [DW-1:0] exp_d;
        write_burst(1, 0, 0, 40);
        send_aw(2, 0, 0);
        send_w({{(DW-8){1'b1}}, 8'hAB}, BY'(1), 1'b1);
        get_b();
        read_burst(3, 0, 0);
        exp_d = pat(40);
        exp_d[7:0] = 8'hAB;
        n_cmp++; if (rd_data[0] !== exp_d) begin
            n_err++; $display("FAIL strobe_data got %h want %h", rd_data[0], exp_d); end
    endtask

    task automatic test_read_stall;
        int n = 0, k = 0;
        logic stalled = 1'b0;
        logic [DW-1:0] held = '0;
        write_burst(4, 10, 7, 100);
        arid = 9'd6; araddr = AW'(10 * BY); arlen = 8'd7; arvalid = 1'b1;
        while (!arready && n < 100) begin tick; n++; end
        tick;
        arvalid = 1'b0; rready = 1'b0; n = 0;
        while (k < 8 && n < 200) begin
            if (stalled) begin
                n_cmp++; if ({rvalid, rdata} !== {1'b1, held}) begin
                    n_err++; $display("FAIL stall_hold got v=%b %h want v=1 %h", rvalid, rdata, held); end
            end
            stalled = 1'b0;
            if (rvalid) begin
                if (rready) begin
                    n_cmp++; if ({rdata, rlast} !== {pat(100 + k), k == 7}) begin
                        n_err++; $display("FAIL stall_beat[%0d] got %h last=%b want %h", k, rdata, rlast, pat(100 + k)); end
                    k++;
                end else begin
                    stalled = 1'b1; held = rdata;
                end
            end
            tick; n++;
            rready = ~rready;
        end
        rready = 1'b0;
        n_cmp++; if (k !== 8) begin
            n_err++; $display("FAIL stall_count got %0d want 8", k); end
    endtask

    task automatic test_wrap;
        write_burst(1, 0, 0, 50);
        write_burst(2, 1023, 1, 60);
        read_burst(3, 1023, 0);
        n_cmp++; if (rd_data[0] !== pat(60)) begin
            n_err++; $display("FAIL wrap_top got %h want %h", rd_data[0], pat(60)); end
        read_burst(3, 0, 0);
`ifdef DMA_AXI_RESP_RANGE_ERR_EN
        n_cmp++; if (b_resp !== 2'b10) begin
            n_err++; $display("FAIL wrap_bresp got %b want 10", b_resp); end
        n_cmp++; if (rd_data[0] !== pat(50)) begin
            n_err++; $display("FAIL wrap_word0 got %h want %h", rd_data[0], pat(50)); end
        read_burst(3, 1023, 1);
        n_cmp++; if ({rd_resp[0], rd_resp[1], rd_data[1]} !== {2'b00, 2'b10, {DW{1'b0}}}) begin
            n_err++; $display("FAIL wrap_rerr got r0=%b r1=%b d1=%h want 00 10 0", rd_resp[0], rd_resp[1], rd_data[1]); end
`else
        n_cmp++; if (b_resp !== 2'b00) begin
            n_err++; $display("FAIL wrap_bresp got %b want 00", b_resp); end
        n_cmp++; if (rd_data[0] !== pat(61)) begin
            n_err++; $display("FAIL wrap_word0 got %h want %h", rd_data[0], pat(61)); end
`endif
    endtask

    task automatic test_concurrent;
        write_burst(1, 20, 0, 70);
        fork
            begin send_aw(3, 20, 0); send_w(pat(71), '1, 1'b1); get_b(); end
            read_burst(4, 20, 0);
        join
        n_cmp++; if ({rd_data[0], rd_id[0]} !== {pat(70), 9'd4}) begin
            n_err++; $display("FAIL conc_read got %h id=%0d want %h id=4", rd_data[0], rd_id[0], pat(70)); end
        n_cmp++; if ({b_id, b_resp} !== {9'd3, 2'b00}) begin
            n_err++; $display("FAIL conc_b got id=%0d resp=%b want id=3 resp=00", b_id, b_resp); end
        read_burst(5, 20, 0);
        n_cmp++; if (rd_data[0] !== pat(71)) begin
            n_err++; $display("FAIL conc_new got %h want %h", rd_data[0], pat(71)); end
    endtask

    task automatic test_reset_mid_read;
        int n = 0, k = 0;
        arid = 9'd9; araddr = AW'(10 * BY); arlen = 8'd7; arvalid = 1'b1;
        while (!arready && n < 100) begin tick; n++; end
        tick;
        arvalid = 1'b0; rready = 1'b1; n = 0;
        while (k < 2 && n < 100) begin if (rvalid) k++; tick; n++; end
        n_cmp++; if (rvalid !== 1'b1) begin
            n_err++; $display("FAIL midrd_active got rvalid=%b want 1", rvalid); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if ({rvalid, rlast, arready} !== 3'b000) begin
            n_err++; $display("FAIL midrd_reset got %b want 000", {rvalid, rlast, arready}); end
        rready = 1'b0;
        repeat (2) tick;
        @(negedge clk) reset_n = 1'b1;
        tick;
        n_cmp++; if ({arready, rvalid} !== 2'b10) begin
            n_err++; $display("FAIL midrd_release got %b want 10", {arready, rvalid}); end
        write_burst(11, 30, 0, 77);
        read_burst(12, 30, 0);
        n_cmp++; if ({rd_data[0], rd_id[0], rd_last[0], rd_resp[0]} !== {pat(77), 9'd12, 1'b1, 2'b00}) begin
            n_err++; $display("FAIL midrd_after got %h id=%0d last=%b resp=%b want %h id=12 last=1 resp=00",
                              rd_data[0], rd_id[0], rd_last[0], rd_resp[0], pat(77)); end
        n_cmp++; if (rd_lat !== 2) begin
            n_err++; $display("FAIL midrd_latency got %0d want 2", rd_lat); end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_strobe();
        test_read_stall();
        test_wrap();
        test_concurrent();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
